mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch port and data-memory port. Each port raises a request. The block arbitrates between them, sequences one access at a time through ISSUE/WAIT/DONE states and returns the response with a one-cycle done pulse. It also generates the per-port stall signals that the pipeline uses to freeze PC/IF_ID and the EX/MEM stage.

Parameters:
ADDR_W, 32, address width of both ports and of the memory.
DATA_W, 32, data width.
MEM_LAT, 2, memory read latency in cycles after the issue cycle; must be at least 1.
STARVE_MAX, 4, consecutive data-port wins allowed while fetch waits (used only with the optional feature).

Ports:
clk_i  in  1  clock; single clock domain
rst_i  in  1  synchronous, active-high reset
if_req_i  in  1  fetch request; held until if_done_o
if_addr_i  in  ADDR_W  fetch address
if_done_o  out  1  one-cycle pulse: fetch complete, if_rdata_o valid
if_rdata_o  out  DATA_W  fetched word; holds until the next fetch completes
if_stall_o  out  1  if_req_i & ~if_done_o
dm_req_i  in  1  data request; held until dm_done_o
dm_we_i  in  1  1 = write, 0 = read
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  write data
dm_done_o  out  1  one-cycle pulse: data access complete
dm_rdata_o  out  DATA_W  read data; holds until the next data read completes
dm_stall_o  out  1  dm_req_i & ~dm_done_o
mem_en_o  out  1  memory access strobe, high for exactly one cycle (ISSUE)
mem_we_o  out  1  memory write enable, qualified by mem_en_o
mem_addr_o  out  ADDR_W  memory address (latched)
mem_wdata_o  out  DATA_W  memory write data (latched)
mem_rdata_i  in  DATA_W  valid in the cycle MEM_LAT cycles after the ISSUE cycle
busy_o  out  1  state != IDLE
owner_o  out  1  owner of the current access: 0 = fetch, 1 = data

Behaviour:
- Reset (sampled at posedge while rst_i=1):
  - state = IDLE; mem_en_o = mem_we_o = 0; mem_addr_o = mem_wdata_o = 0.
  - if_done_o = dm_done_o = 0; if_rdata_o = dm_rdata_o = 0; owner_o = 0.
  - Wait counter and starve counter = 0.
  - Reset mid-access discards the in-flight access. No done pulse is issued. A write already strobed to memory stands.
- IDLE: arbitration is evaluated at every edge.
  - Only one request pending: that port wins.
  - Both pending: data port wins (strict priority), except as modified by the optional feature.
  - On a win: latch owner, address, write enable and wdata (wdata forced to 0 for fetch, mem_we_o = 0 for fetch); go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (1 cycle): mem_en_o = 1. Load wait counter with MEM_LAT. Go to WAIT.
- WAIT: decrement the counter each cycle.
  - In the cycle where the counter equals 1, mem_rdata_i is valid. It is captured into the owner's rdata register, reads only; writes leave dm_rdata_o unchanged.
  - Then go to DONE.
  - WAIT therefore lasts MEM_LAT cycles.
- DONE (1 cycle): the owner's done_o = 1. Requests are ignored. Always go to IDLE.
- Requesters must drop or replace req in the cycle after done. A req still high in the following IDLE is treated as a new access.
- Latency: req first sampled in IDLE at cycle 0 -> ISSUE at cycle 1 -> done at cycle MEM_LAT+2. One access per MEM_LAT+3 cycles under back-to-back requests.
- A request arriving while busy_o=1 waits. Its stall output stays high; no request is lost.
- Port inputs are sampled only in IDLE. Changes to them during an access have no effect on that access.
- Done pulses for both ports never coincide.

Optional Feature:
MEMARB_STARVE_GUARD_EN
- Defined:
  - A starve counter increments on each data win while if_req_i is high.
  - When the counter equals STARVE_MAX and both ports request, the fetch port wins.
  - The counter clears on any fetch win or when if_req_i is low in IDLE.
- Not defined: strict data priority; no starve counter logic is present.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - owner constants OWN_IF = 0 and OWN_DM = 1;
  - the default widths.
- One natural sub-module: mem_arb_pick, a combinational winner select that also contains the starve counter when the feature is enabled. The FSM and datapath registers stay in the top module.

Test Plan:
- Single fetch: MEM_LAT=2, if_req_i=1, addr 0x10, memory returns 0xDEADBEEF -> mem_en_o at cycle 1, if_done_o at cycle 4, if_rdata_o=0xDEADBEEF, if_stall_o high in cycles 0-3.
- Simultaneous requests: fetch 0x20 and data read 0x100 both at cycle 0 -> data served first (done at cycle 4, owner_o=1), then fetch (done at cycle 9).
- Data write: dm_we_i=1, addr 0x40, wdata 0x1234 -> mem_we_o=1 with mem_en_o in exactly one cycle, dm_done_o at cycle 4, dm_rdata_o unchanged.
- Reset mid-access: rst_i=1 during WAIT -> next cycle busy_o=0, no done pulse. A subsequent request completes normally.
- Starvation, with MEMARB_STARVE_GUARD_EN and STARVE_MAX=4: fetch held high while data requests back-to-back -> fetch granted after exactly 4 data completions. Without the macro, fetch waits until dm_req_i drops.
- MEM_LAT=1 boundary: single read -> done at cycle 3; data captured in the first WAIT cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encoding, access owner codes and default widths.
package mem_arb_pkg;

  // Default geometry of the shared unified memory.
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;

  // Owner of the access currently in flight.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Access sequencer states; explicit codes keep the encoding stable
  // for anyone probing the state register in a waveform or netlist.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width needed to hold a down-counter loaded with 'lat'.
  function automatic int lat_cnt_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the shared memory port. Data has strict priority
// over fetch. When MEMARB_STARVE_GUARD_EN is defined a starve counter
// tracks consecutive data wins while fetch is waiting and hands the
// port to fetch once STARVE_MAX such wins have occurred.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arb_en_i,   // sequencer is idle and may start an access
  input  logic if_req_i,
  input  logic dm_req_i,
  output logic win_o,      // an access starts this cycle
  output logic owner_o     // OWN_IF / OWN_DM
);

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          starved;

  assign starved = (starve_q >= SW'(STARVE_MAX));

  // Winner: data unless fetch has been passed over STARVE_MAX times.
  always_comb begin
    win_o   = arb_en_i & (if_req_i | dm_req_i);
    owner_o = (dm_req_i && !(if_req_i && starved)) ? OWN_DM : OWN_IF;
  end

  // Starve counter next state: count data wins seen by a waiting fetch.
  always_comb begin
    starve_d = starve_q;
    if (arb_en_i) begin
      if (!if_req_i) begin
        starve_d = '0;
      end else if (win_o && owner_o == OWN_DM) begin
        starve_d = starve_q + SW'(1);
      end else if (win_o && owner_o == OWN_IF) begin
        starve_d = '0;
      end
    end
  end

  // Starve counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic        unused_clk_rst;
  logic [31:0] unused_starve_max;

  assign unused_clk_rst    = clk_i ^ rst_i;
  assign unused_starve_max = STARVE_MAX;

  // Winner: strict data priority, purely combinational.
  always_comb begin
    win_o   = arb_en_i & (if_req_i | dm_req_i);
    owner_o = dm_req_i ? OWN_DM : OWN_IF;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between the fetch port
// and the data port. One access at a time runs IDLE -> ISSUE -> WAIT
// (MEM_LAT cycles) -> DONE; the owner gets a one-cycle done pulse.
// Optional build macro: MEMARB_STARVE_GUARD_EN (fetch anti-starvation).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // fetch port
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  // data port
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_done_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_stall_o,
  // memory side
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  // status
  output logic              busy_o,
  output logic              owner_o
);

  localparam int                CNT_W  = lat_cnt_w(MEM_LAT);
  localparam logic [CNT_W-1:0]  LAT_LD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

  logic                pick_win;
  logic                pick_owner;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .arb_en_i (state_q == ST_IDLE),
    .if_req_i (if_req_i),
    .dm_req_i (dm_req_i),
    .win_o    (pick_win),
    .owner_o  (pick_owner)
  );

  // Sequencer next state and datapath latches; port inputs are only
  // looked at in IDLE so mid-access changes cannot disturb the access.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_win) begin
          owner_d = pick_owner;
          if (pick_owner == OWN_DM) begin
            addr_d  = dm_addr_i;
            we_d    = dm_we_i;
            wdata_d = dm_wdata_i;
          end else begin
            addr_d  = if_addr_i;
            we_d    = 1'b0;
            wdata_d = '0;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = LAT_LD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        // Last WAIT cycle: memory read data is valid right now.
        if (cnt_q == CNT_ONE) begin
          if (!we_q) begin
            if (owner_q == OWN_DM) begin
              dm_rdata_d = mem_rdata_i;
            end else begin
              if_rdata_d = mem_rdata_i;
            end
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Outputs decoded from registered state; stalls follow the live request.
  always_comb begin
    mem_en_o    = (state_q == ST_ISSUE);
    mem_we_o    = (state_q == ST_ISSUE) & we_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    if_done_o   = (state_q == ST_DONE) & (owner_q == OWN_IF);
    dm_done_o   = (state_q == ST_DONE) & (owner_q == OWN_DM);
    if_rdata_o  = if_rdata_q;
    dm_rdata_o  = dm_rdata_q;
    busy_o      = (state_q != ST_IDLE);
    owner_o     = owner_q;
    if_stall_o  = if_req_i & ~if_done_o;
    dm_stall_o  = dm_req_i & ~dm_done_o;
  end

endmodule
